// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_LATENCY = 2;

    // Word-index width for an array of the given depth (at least one bit).
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data array: byte-enabled synchronous write, asynchronous read.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned AW          = idx_width(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [3:0]    be,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage load/store target: single-cycle stores, fixed-latency loads with stall request.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned LATENCY     = DEFAULT_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        resp_valid,
    output logic        busy,
    output logic        err
);

    localparam int unsigned AW = idx_width(DEPTH_WORDS);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        req_legal;
    logic        st_req;
    logic        ld_req;
    logic [31:0] rd_addr;
    logic        rd_legal;
    logic [31:0] rd_word;

    function automatic logic is_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ({2'b00, a[31:2]} < 32'(DEPTH_WORDS));
    endfunction

    assign req_legal = is_legal(addr);
    assign st_req    = (state == IDLE) && req_valid && we;
    assign ld_req    = (state == IDLE) && req_valid && !we;

    // In IDLE the live address feeds the read port so LATENCY=1 can respond next cycle.
    assign rd_addr   = (state == IDLE) ? addr : addr_q;
    assign rd_legal  = is_legal(rd_addr);

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .wr_en (st_req && req_legal),
        .be    (be),
        .waddr (addr[AW+1:2]),
        .wdata (wdata),
        .raddr (rd_addr[AW+1:2]),
        .rdata (rd_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_q  <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ld_req) begin
                        addr_q <= addr;
                        cnt    <= 4'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            rdata_q <= rd_legal ? rd_word : 32'd0;
                            err_q   <= !rd_legal;
                            state   <= RESP;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    // Transition on the edge where the count reaches zero.
                    if (cnt <= 4'd1) begin
                        rdata_q <= rd_legal ? rd_word : 32'd0;
                        err_q   <= !rd_legal;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rdata      = rdata_q;
    assign resp_valid = (state == RESP);
    assign busy       = (state == WAIT) || ld_req;
    assign err        = ((state == RESP) && err_q) || (st_req && !req_legal);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: cycle vector table plus reset and held-request sequences.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        resp_valid;
    logic        busy;
    logic        err;

    logic        rst4 = 1'b0;
    logic        rv4 = 1'b0;
    logic        we4 = 1'b0;
    logic [3:0]  be4 = 4'h0;
    logic [31:0] addr4 = 32'h0;
    logic [31:0] wdata4 = 32'h0;
    logic [31:0] rdata4;
    logic        resp_valid4;
    logic        busy4;
    logic        err4;

    int tests = 0;
    int fails = 0;

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .we         (we),
        .be         (be),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .resp_valid (resp_valid),
        .busy       (busy),
        .err        (err)
    );

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(4)) u_dut4 (
        .clk        (clk),
        .reset      (rst4),
        .req_valid  (rv4),
        .we         (we4),
        .be         (be4),
        .addr       (addr4),
        .wdata      (wdata4),
        .rdata      (rdata4),
        .resp_valid (resp_valid4),
        .busy       (busy4),
        .err        (err4)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        rv;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        busy;
        logic        rvld;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [30];

    function automatic vec_t v(input logic rv_i, input logic we_i, input logic [3:0] be_i,
                               input logic [31:0] a_i, input logic [31:0] d_i,
                               input logic b_i, input logic r_i, input logic e_i,
                               input logic [31:0] q_i);
        vec_t t;
        t.rv = rv_i; t.we = we_i; t.be = be_i; t.addr = a_i; t.wdata = d_i;
        t.busy = b_i; t.rvld = r_i; t.err = e_i; t.rdata = q_i;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic rv_i, input logic we_i, input logic [3:0] be_i,
                       input logic [31:0] a_i, input logic [31:0] d_i);
        @(posedge clk);
        #1;
        req_valid = rv_i; we = we_i; be = be_i; addr = a_i; wdata = d_i;
        @(negedge clk);
    endtask

    task automatic cyc4(input logic rv_i, input logic we_i, input logic [3:0] be_i,
                        input logic [31:0] a_i, input logic [31:0] d_i);
        @(posedge clk);
        #1;
        rv4 = rv_i; we4 = we_i; be4 = be_i; addr4 = a_i; wdata4 = d_i;
        @(negedge clk);
    endtask

    initial begin
        int n;
        int pulses;
        n = 0;
        // store / load / partial store
        vecs[n++] = v(1,1,4'hF,32'h10,32'hDEADBEEF, 0,0,0,32'h0);
        vecs[n++] = v(1,0,4'h0,32'h10,32'h0,        1,0,0,32'h0);
        vecs[n++] = v(0,0,4'h0,32'h0, 32'h0,        1,0,0,32'h0);
        vecs[n++] = v(0,0,4'h0,32'h0, 32'h0,        0,1,0,32'hDEADBEEF);
        vecs[n++] = v(1,1,4'h1,32'h10,32'h000000AA, 0,0,0,32'hDEADBEEF);
        vecs[n++] = v(1,0,4'h0,32'h10,32'h0,        1,0,0,32'hDEADBEEF);
        vecs[n++] = v(0,0,4'h0,32'h0, 32'h0,        1,0,0,32'hDEADBEEF);
        vecs[n++] = v(0,0,4'h0,32'h0, 32'h0,        0,1,0,32'hDEADBEAA);
        // misaligned store then load of the untouched word
        vecs[n++] = v(1,1,4'hF,32'h12,32'h11223344, 0,0,1,32'hDEADBEAA);
        vecs[n++] = v(1,0,4'h0,32'h10,32'h0,        1,0,0,32'hDEADBEAA);
        vecs[n++] = v(0,0,4'h0,32'h0, 32'h0,        1,0,0,32'hDEADBEAA);
        vecs[n++] = v(0,0,4'h0,32'h0, 32'h0,        0,1,0,32'hDEADBEAA);
        // out-of-range load right after RESP
        vecs[n++] = v(1,0,4'h0,32'h100,32'h0,       1,0,0,32'hDEADBEAA);
        vecs[n++] = v(0,0,4'h0,32'h0, 32'h0,        1,0,0,32'hDEADBEAA);
        vecs[n++] = v(0,0,4'h0,32'h0, 32'h0,        0,1,1,32'h0);
        vecs[n++] = v(0,0,4'h0,32'h0, 32'h0,        0,0,0,32'h0);
        // out-of-range store, last legal word, request held into RESP
        vecs[n++] = v(1,1,4'hF,32'h100,32'hFFFFFFFF,0,0,1,32'h0);
        vecs[n++] = v(1,1,4'hF,32'hFC,32'hCAFEF00D, 0,0,0,32'h0);
        vecs[n++] = v(1,0,4'h0,32'hFC,32'h0,        1,0,0,32'h0);
        vecs[n++] = v(0,0,4'h0,32'h0, 32'h0,        1,0,0,32'h0);
        vecs[n++] = v(1,0,4'h0,32'h10,32'h0,        0,1,0,32'hCAFEF00D);
        vecs[n++] = v(0,0,4'h0,32'h0, 32'h0,        0,0,0,32'hCAFEF00D);
        // middle-byte store; stores during WAIT are ignored
        vecs[n++] = v(1,1,4'hF,32'h20,32'h12345678, 0,0,0,32'hCAFEF00D);
        vecs[n++] = v(1,1,4'h6,32'h20,32'hAABBCCDD, 0,0,0,32'hCAFEF00D);
        vecs[n++] = v(1,0,4'h0,32'h20,32'h0,        1,0,0,32'hCAFEF00D);
        vecs[n++] = v(1,1,4'hF,32'h20,32'h0,        1,0,0,32'hCAFEF00D);
        vecs[n++] = v(0,0,4'h0,32'h0, 32'h0,        0,1,0,32'h12BBCC78);
        vecs[n++] = v(1,0,4'h0,32'h20,32'h0,        1,0,0,32'h12BBCC78);
        vecs[n++] = v(1,1,4'hF,32'h22,32'h0,        1,0,0,32'h12BBCC78);
        vecs[n++] = v(0,0,4'h0,32'h0, 32'h0,        0,1,0,32'h12BBCC78);

        #1;
        reset = 1'b1;
        rst4  = 1'b1;
        #2;
        check("reset busy",  32'(busy), 32'h0);
        check("reset rvld",  32'(resp_valid), 32'h0);
        check("reset err",   32'(err), 32'h0);
        check("reset rdata", rdata, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        rst4  = 1'b0;

        for (int i = 0; i < n; i++) begin
            cyc(vecs[i].rv, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata);
            check($sformatf("vec%0d busy", i),  32'(busy),       32'(vecs[i].busy));
            check($sformatf("vec%0d rvld", i),  32'(resp_valid), 32'(vecs[i].rvld));
            check($sformatf("vec%0d err", i),   32'(err),        32'(vecs[i].err));
            check($sformatf("vec%0d rdata", i), rdata,           vecs[i].rdata);
        end

        // Held request with addr changing during WAIT: original address, one pulse.
        cyc(0,0,4'h0,32'h0,32'h0);
        pulses = 0;
        cyc(1,0,4'h0,32'h10,32'h0);
        check("held busy T", 32'(busy), 32'h1);
        cyc(1,0,4'h0,32'h20,32'h0);
        check("held busy T+1", 32'(busy), 32'h1);
        cyc(1,0,4'h0,32'h20,32'h0);
        check("held rvld", 32'(resp_valid), 32'h1);
        check("held rdata", rdata, 32'hDEADBEAA);
        for (int k = 0; k < 4; k++) begin
            if (resp_valid) pulses++;
            cyc(0,0,4'h0,32'h0,32'h0);
        end
        check("held pulse count", 32'(pulses), 32'd1);

        // LATENCY=4: a full load, then reset in the 2nd WAIT cycle.
        cyc4(1,1,4'hF,32'h4,32'h55AA55AA);
        cyc4(1,0,4'h0,32'h4,32'h0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("lat4 busy w%0d", k), 32'(busy4), 32'h1);
            cyc4(0,0,4'h0,32'h0,32'h0);
        end
        check("lat4 busy w3", 32'(busy4), 32'h1);
        cyc4(0,0,4'h0,32'h0,32'h0);
        check("lat4 rvld", 32'(resp_valid4), 32'h1);
        check("lat4 busy resp", 32'(busy4), 32'h0);
        check("lat4 rdata", rdata4, 32'h55AA55AA);
        cyc4(1,0,4'h0,32'h4,32'h0);
        cyc4(0,0,4'h0,32'h0,32'h0);
        cyc4(0,0,4'h0,32'h0,32'h0);
        check("rst4 pre busy", 32'(busy4), 32'h1);
        rst4 = 1'b1;
        #1;
        check("rst4 busy",  32'(busy4), 32'h0);
        check("rst4 rvld",  32'(resp_valid4), 32'h0);
        check("rst4 rdata", rdata4, 32'h0);
        @(posedge clk);
        #1;
        rst4 = 1'b0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            cyc4(0,0,4'h0,32'h0,32'h0);
            if (resp_valid4 || busy4) pulses++;
        end
        check("rst4 no response", 32'(pulses), 32'd0);
        cyc4(1,0,4'h0,32'h4,32'h0);
        check("rst4 reload busy", 32'(busy4), 32'h1);
        for (int k = 0; k < 4; k++) cyc4(0,0,4'h0,32'h0,32'h0);
        check("rst4 reload rvld", 32'(resp_valid4), 32'h1);
        check("rst4 reload rdata", rdata4, 32'h55AA55AA);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
